// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath, PC and IR enables.
// Latency: BEQ/J 3, SW/R/ADDI 4, LW 5 cycles with zero-wait memory; every memory wait cycle adds one.
// Backpressure: Mem_Req is held until Mem_Ready; MULTICYCLE_CTRL_MEM_TIMEOUT_EN bounds the wait to TIMEOUT cycles, then FAULT.
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       Mem_Req,
    output logic       Pc_Write,
    output logic       Ir_Write,
    output logic       RegDest,
    output logic       Jump,
    output logic       Branch,
    output logic       Sig_Mem_Read,
    output logic       Sig_Mem_to_Reg,
    output logic       Sig_Mem_Write,
    output logic       ALUSrc,
    output logic       Sig_Reg_Write,
    output logic [2:0] ALUOp,
    output logic [2:0] State,
    output logic       Halted,
    output logic       Fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef struct packed {
        logic       mem_req;
        logic       reg_dest;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       halted;
        logic       fault;
        logic [2:0] alu_op;
    } ctl_t;

    state_t     state;
    state_t     state_n;
    logic [5:0] op_q;
    ctl_t       ctl_q;
    logic       timeout_hit;

    // Moore controls for the state being entered, so they can be registered.
    function automatic ctl_t decode_ctl(input state_t st, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_req  = 1'b1;
                c.mem_read = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_R:    begin c.reg_dest = 1'b1; c.alu_op = 3'b010; end
                    OP_ADDI: c.alu_src = 1'b1;
                    OP_LW:   c.alu_src = 1'b1;
                    OP_SW:   c.alu_src = 1'b1;
                    OP_BEQ:  begin c.branch = 1'b1; c.alu_op = 3'b001; end
                    OP_J:    c.jump = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                c.mem_req   = 1'b1;
                c.alu_src   = 1'b1;
                c.mem_read  = (op == OP_LW);
                c.mem_write = (op == OP_SW);
            end
            S_WB: begin
                c.reg_write = 1'b1;
                case (op)
                    OP_LW:   c.mem_to_reg = 1'b1;
                    OP_R:    begin c.reg_dest = 1'b1; c.alu_op = 3'b010; end
                    OP_ADDI: c.alu_src = 1'b1;
                    default: ;
                endcase
            end
            S_HALT:  c.halted = 1'b1;
            S_FAULT: c.fault  = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        state_n = state;
        case (state)
            S_FETCH: begin
                if (ctl_q.mem_req && Mem_Ready) state_n = S_DECODE;
                else if (timeout_hit)           state_n = S_FAULT;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_HALT:                                    state_n = S_HALT;
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: state_n = S_EXEC;
                    default:                                    state_n = S_FAULT;
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_ADDI: state_n = S_WB;
                    OP_LW, OP_SW:  state_n = S_MEM;
                    OP_BEQ, OP_J:  state_n = S_FETCH;
                    default:       state_n = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (Mem_Ready)        state_n = (op_q == OP_LW) ? S_WB : S_FETCH;
                else if (timeout_hit) state_n = S_FAULT;
            end
            S_WB:    state_n = S_FETCH;
            default: state_n = state;
        endcase
    end

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] to_cnt;
    logic          waiting;

    assign waiting     = ctl_q.mem_req && !Mem_Ready;
    // Fires on the TIMEOUT-th consecutive unanswered request cycle; a Ready on that cycle still wins.
    assign timeout_hit = waiting && (to_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                   to_cnt <= '0;
        else if (state_n != state) to_cnt <= '0;
        else if (waiting)          to_cnt <= to_cnt + 1'b1;
    end
`else
    // Unbounded memory waits; the comparison only keeps TIMEOUT referenced.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_FETCH;
            op_q  <= '0;
            ctl_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) op_q <= Opcode;
            ctl_q <= decode_ctl(state_n, (state == S_DECODE) ? Opcode : op_q);
        end
    end

    // Write enables that depend on same-cycle Mem_Ready or Zero stay combinational.
    assign Ir_Write = !Rst && (state == S_FETCH) && ctl_q.mem_req && Mem_Ready;
    assign Pc_Write = Ir_Write ||
                      (!Rst && (state == S_EXEC) &&
                       ((op_q == OP_J) || ((op_q == OP_BEQ) && Zero)));

    assign Mem_Req        = ctl_q.mem_req;
    assign RegDest        = ctl_q.reg_dest;
    assign Jump           = ctl_q.jump;
    assign Branch         = ctl_q.branch;
    assign Sig_Mem_Read   = ctl_q.mem_read;
    assign Sig_Mem_to_Reg = ctl_q.mem_to_reg;
    assign Sig_Mem_Write  = ctl_q.mem_write;
    assign ALUSrc         = ctl_q.alu_src;
    assign Sig_Reg_Write  = ctl_q.reg_write;
    assign ALUOp          = ctl_q.alu_op;
    assign Halted         = ctl_q.halted;
    assign Fault          = ctl_q.fault;
    assign State          = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues one expected output vector per cycle, monitor compares at negedge.
module tb_multicycle_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [5:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       Mem_Ready = 1'b0;
    logic       Mem_Req, Pc_Write, Ir_Write, RegDest, Jump, Branch;
    logic       Sig_Mem_Read, Sig_Mem_to_Reg, Sig_Mem_Write, ALUSrc, Sig_Reg_Write;
    logic [2:0] ALUOp, State;
    logic       Halted, Fault;

    multicycle_ctrl #(.TIMEOUT(16)) dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Zero(Zero), .Mem_Ready(Mem_Ready),
        .Mem_Req(Mem_Req), .Pc_Write(Pc_Write), .Ir_Write(Ir_Write), .RegDest(RegDest),
        .Jump(Jump), .Branch(Branch), .Sig_Mem_Read(Sig_Mem_Read), .Sig_Mem_to_Reg(Sig_Mem_to_Reg),
        .Sig_Mem_Write(Sig_Mem_Write), .ALUSrc(ALUSrc), .Sig_Reg_Write(Sig_Reg_Write),
        .ALUOp(ALUOp), .State(State), .Halted(Halted), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    localparam logic [12:0] REQ  = 13'h1000;
    localparam logic [12:0] PCW  = 13'h0800;
    localparam logic [12:0] IRW  = 13'h0400;
    localparam logic [12:0] RD   = 13'h0200;
    localparam logic [12:0] JMP  = 13'h0100;
    localparam logic [12:0] BR   = 13'h0080;
    localparam logic [12:0] MRD  = 13'h0040;
    localparam logic [12:0] M2R  = 13'h0020;
    localparam logic [12:0] MWR  = 13'h0010;
    localparam logic [12:0] ASRC = 13'h0008;
    localparam logic [12:0] RW   = 13'h0004;
    localparam logic [12:0] HLT  = 13'h0002;
    localparam logic [12:0] FLT  = 13'h0001;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_BAD  = 6'b010101;

    logic [18:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [18:0] act;
    assign act = {State, ALUOp, Mem_Req, Pc_Write, Ir_Write, RegDest, Jump, Branch,
                  Sig_Mem_Read, Sig_Mem_to_Reg, Sig_Mem_Write, ALUSrc, Sig_Reg_Write, Halted, Fault};

    // Monitor: one expected vector per stimulus cycle, compared mid-cycle.
    always @(negedge Clk) begin
        logic [18:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got {st,aluop,flags}=%b required %b", n, act, e);
            end
        end
    end

    task automatic cyc(input logic [2:0] st, input logic [2:0] aop, input logic [12:0] fl,
                       input logic [5:0] op, input logic z, input logic rdy, input string nm);
        @(posedge Clk);
        #1;
        Opcode    = op;
        Zero      = z;
        Mem_Ready = rdy;
        exp_q.push_back({st, aop, fl});
        name_q.push_back(nm);
    endtask

    task automatic do_reset(input string nm);
        @(posedge Clk);
        #1;
        Rst       = 1'b1;
        Mem_Ready = 1'b1;
        exp_q.push_back('0);
        name_q.push_back({nm, "_hold"});
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        exp_q.push_back('0);
        name_q.push_back({nm, "_release"});
    endtask

    task automatic fetch(input logic [5:0] op, input string nm);
        cyc(3'd0, 3'b000, REQ | MRD | PCW | IRW, op, 1'b0, 1'b1, {nm, "_fetch"});
        cyc(3'd1, 3'b000, 13'h0, op, 1'b0, 1'b1, {nm, "_decode"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("rst");

        fetch(OP_R, "r");
        cyc(3'd2, 3'b010, RD,      OP_R, 1'b0, 1'b1, "r_exec");
        cyc(3'd4, 3'b010, RW | RD, OP_R, 1'b0, 1'b1, "r_wb");

        fetch(OP_ADDI, "addi");
        cyc(3'd2, 3'b000, ASRC,      OP_ADDI, 1'b0, 1'b1, "addi_exec");
        cyc(3'd4, 3'b000, RW | ASRC, OP_ADDI, 1'b0, 1'b1, "addi_wb");

        fetch(OP_LW, "lw");
        cyc(3'd2, 3'b000, ASRC,             OP_LW, 1'b0, 1'b1, "lw_exec");
        cyc(3'd3, 3'b000, REQ | ASRC | MRD, OP_LW, 1'b0, 1'b0, "lw_mem_wait1");
        cyc(3'd3, 3'b000, REQ | ASRC | MRD, OP_LW, 1'b0, 1'b0, "lw_mem_wait2");
        cyc(3'd3, 3'b000, REQ | ASRC | MRD, OP_LW, 1'b0, 1'b1, "lw_mem_ready");
        cyc(3'd4, 3'b000, RW | M2R,         OP_LW, 1'b0, 1'b1, "lw_wb");

        fetch(OP_BEQ, "beq0");
        cyc(3'd2, 3'b001, BR,       OP_BEQ, 1'b0, 1'b1, "beq0_exec");
        fetch(OP_BEQ, "beq1");
        cyc(3'd2, 3'b001, BR | PCW, OP_BEQ, 1'b1, 1'b1, "beq1_exec");

        fetch(OP_J, "j");
        cyc(3'd2, 3'b000, JMP | PCW, OP_J, 1'b0, 1'b1, "j_exec");

        fetch(OP_SW, "sw");
        cyc(3'd2, 3'b000, ASRC,             OP_SW, 1'b0, 1'b1, "sw_exec");
        cyc(3'd3, 3'b000, REQ | ASRC | MWR, OP_SW, 1'b0, 1'b0, "sw_mem_wait");
        cyc(3'd3, 3'b000, REQ | ASRC | MWR, OP_SW, 1'b0, 1'b1, "sw_mem_ready");

        fetch(OP_SW, "swabort");
        cyc(3'd2, 3'b000, ASRC,             OP_SW, 1'b0, 1'b1, "swabort_exec");
        cyc(3'd3, 3'b000, REQ | ASRC | MWR, OP_SW, 1'b0, 1'b0, "swabort_wait1");
        cyc(3'd3, 3'b000, REQ | ASRC | MWR, OP_SW, 1'b0, 1'b0, "swabort_wait2");
        do_reset("swabort_rst");
        fetch(OP_J, "after_abort");
        cyc(3'd2, 3'b000, JMP | PCW, OP_J, 1'b0, 1'b1, "after_abort_exec");

        fetch(OP_HALT, "halt");
        for (int i = 0; i < 20; i++)
            cyc(3'd5, 3'b000, HLT, OP_HALT, 1'b0, i[0], $sformatf("halt_hold%0d", i));

        do_reset("rst_bad");
        fetch(OP_BAD, "bad");
        for (int i = 0; i < 3; i++)
            cyc(3'd6, 3'b000, FLT, OP_BAD, 1'b0, 1'b1, $sformatf("bad_fault%0d", i));

        // Ready arriving on the last allowed wait cycle still completes the fetch.
        do_reset("rst_rdywin");
        for (int i = 0; i < 15; i++)
            cyc(3'd0, 3'b000, REQ | MRD, OP_R, 1'b0, 1'b0, $sformatf("rdywin_wait%0d", i));
        cyc(3'd0, 3'b000, REQ | MRD | PCW | IRW, OP_R, 1'b0, 1'b1, "rdywin_ready");
        cyc(3'd1, 3'b000, 13'h0,   OP_R, 1'b0, 1'b1, "rdywin_decode");
        cyc(3'd2, 3'b010, RD,      OP_R, 1'b0, 1'b1, "rdywin_exec");
        cyc(3'd4, 3'b010, RW | RD, OP_R, 1'b0, 1'b1, "rdywin_wb");

        do_reset("rst_timeout");
        for (int i = 0; i < 16; i++)
            cyc(3'd0, 3'b000, REQ | MRD, OP_R, 1'b0, 1'b0, $sformatf("to_wait%0d", i));
`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
        cyc(3'd6, 3'b000, FLT, OP_R, 1'b0, 1'b0, "to_fault0");
        cyc(3'd6, 3'b000, FLT, OP_R, 1'b0, 1'b1, "to_fault1");
        cyc(3'd6, 3'b000, FLT, OP_R, 1'b0, 1'b0, "to_fault2");
`else
        for (int i = 16; i < 40; i++)
            cyc(3'd0, 3'b000, REQ | MRD, OP_R, 1'b0, 1'b0, $sformatf("to_wait%0d", i));
`endif

        @(posedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
